nibble_seq_alu: RTL and testbench



---
 rtl/nibble_seq_alu.sv | 154 +++++++++++++++
 tb/tb_nibble_seq_alu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_seq_alu.sv
// nibble_seq_alu: 16-bit add/sub using one 4-bit slice, LS nibble first.
// Optional signed-overflow flag port OF enabled by macro OVF_FLAG_EN.
module nibble_seq_alu (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ADD_SUB,
  input  logic        C0,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] F,
  output logic        C16,
  output logic        CF,
  output logic        ZF,
  output logic        BUSY,
`ifdef OVF_FLAG_EN
  output logic        OF,
`endif
  output logic        DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ncnt_q, ncnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic        cy_q, cy_d;
  logic [15:0] res_q, res_d;
  logic [15:0] f_q, f_d;
  logic        c16_q, c16_d;
  logic        cf_q, cf_d;
  logic        zf_q, zf_d;
`ifdef OVF_FLAG_EN
  logic        of_q, of_d;
`endif

  logic [3:0]  a_n;
  logic [3:0]  b_n;
  logic [4:0]  slice;
  logic [15:0] fin;

  // bit 4 of the slice is carry for add and borrow for subtract
  always_comb begin
    a_n = a_q[{ncnt_q, 2'b00} +: 4];
    b_n = b_q[{ncnt_q, 2'b00} +: 4];
    if (sub_q)
      slice = {1'b0, a_n} - {1'b0, b_n} - {4'b0000, cy_q};
    else
      slice = {1'b0, a_n} + {1'b0, b_n} + {4'b0000, cy_q};
    fin = {slice[3:0], res_q[11:0]};
  end

  always_comb begin
    state_d = state_q;
    ncnt_d  = ncnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    cy_d    = cy_q;
    res_d   = res_q;
    f_d     = f_q;
    c16_d   = c16_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
`ifdef OVF_FLAG_EN
    of_d    = of_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          sub_d   = ADD_SUB;
          cy_d    = C0;
          ncnt_d  = 2'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[{ncnt_q, 2'b00} +: 4] = slice[3:0];
        cy_d   = slice[4];
        ncnt_d = ncnt_q + 2'd1;
        if (ncnt_q == 2'd3) begin
          state_d = S_DONE;
          f_d     = fin;
          c16_d   = slice[4];
          cf_d    = slice[4] ^ sub_q;
          zf_d    = (fin == 16'h0000);
`ifdef OVF_FLAG_EN
          of_d = (a_q[15] == (b_q[15] ^ sub_q))
              && (fin[15] != a_q[15]);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ncnt_q  <= 2'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      sub_q   <= 1'b0;
      cy_q    <= 1'b0;
      res_q   <= 16'h0000;
      f_q     <= 16'h0000;
      c16_q   <= 1'b0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b0;
`ifdef OVF_FLAG_EN
      of_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ncnt_q  <= ncnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      f_q     <= f_d;
      c16_q   <= c16_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
`ifdef OVF_FLAG_EN
      of_q    <= of_d;
`endif
    end
  end

  assign F    = f_q;
  assign C16  = c16_q;
  assign CF   = cf_q;
  assign ZF   = zf_q;
  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_DONE);
`ifdef OVF_FLAG_EN
  assign OF   = of_q;
`endif

endmodule

// File: tb/tb_nibble_seq_alu.sv
// Directed scoreboard bench for nibble_seq_alu.
// Exercises OF checks when OVF_FLAG_EN is defined.
module tb_nibble_seq_alu;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        ADD_SUB = 1'b0;
  logic        C0 = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic [15:0] F;
  logic        C16, CF, ZF, BUSY, DONE;
`ifdef OVF_FLAG_EN
  logic        OF;
`endif

  typedef struct packed {
    logic [15:0] f;
    logic        c16;
    logic        cf;
    logic        zf;
    logic        of;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;

  nibble_seq_alu dut (
    .CLK(CLK), .RST(RST), .START(START),
    .ADD_SUB(ADD_SUB), .C0(C0), .A(A), .B(B),
    .F(F), .C16(C16), .CF(CF), .ZF(ZF),
    .BUSY(BUSY),
`ifdef OVF_FLAG_EN
    .OF(OF),
`endif
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (DONE) n_done <= n_done + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic c0,
                                 input logic sub);
    exp_t e;
    logic [16:0] r;
    logic [15:0] bp;
    if (sub) r = {1'b0, a} - {1'b0, b} - {16'h0, c0};
    else     r = {1'b0, a} + {1'b0, b} + {16'h0, c0};
    bp = sub ? ~b : b;
    e.f   = r[15:0];
    e.c16 = r[16];
    e.cf  = sub ? ~r[16] : r[16];
    e.zf  = (r[15:0] == 16'h0000);
    e.of  = (a[15] == bp[15]) && (r[15] != a[15]);
    return e;
  endfunction

  // drive one request; returns at the negedge after the accept edge
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic c0, input logic sub,
                          input bit push);
    @(negedge CLK);
    A = a; B = b; C0 = c0; ADD_SUB = sub; START = 1'b1;
    if (push) sb.push_back(model(a, b, c0, sub));
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    int busy;
    exp_t e;
    lat = 0;
    busy = 0;
    while (!DONE && lat < 16) begin
      if (BUSY) busy++;
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_busy"}, busy, 4);
    chk({tag, "_busy_at_done"}, BUSY, 1'b0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_f"}, F, e.f);
      chk({tag, "_c16"}, C16, e.c16);
      chk({tag, "_cf"}, CF, e.cf);
      chk({tag, "_zf"}, ZF, e.zf);
`ifdef OVF_FLAG_EN
      chk({tag, "_of"}, OF, e.of);
`endif
    end
  endtask

  initial begin
    int d0;
    logic [15:0] hold_f;

    repeat (3) @(negedge CLK);
    RST = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    RST = 1'b0;
    chk("rst_f", F, 16'h0000);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_flags", {C16, CF, ZF}, 3'b000);

    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1);
    wait_done("add_ff");
    chk("add_ff_lit", F, 16'h0100);

    start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1);
    wait_done("add_wrap");
    chk("add_wrap_lit", {F, C16, CF, ZF}, {16'h0000, 3'b111});

    start_op(16'h1000, 16'h0001, 1'b0, 1'b1, 1);
    wait_done("sub_1000");
    chk("sub_1000_lit", {F, C16, CF}, {16'h0FFF, 2'b01});

    start_op(16'h0000, 16'h0001, 1'b0, 1'b1, 1);
    wait_done("sub_0");
    chk("sub_0_lit", {F, C16, CF, ZF}, {16'hFFFF, 3'b100});

    hold_f = F;
    repeat (5) @(negedge CLK);
    chk("hold_f", F, hold_f);
    chk("hold_c16", C16, 1'b1);

    // START stays high; operands change mid-flight
    @(negedge CLK);
    A = 16'h0003; B = 16'h0004; C0 = 1'b0; ADD_SUB = 1'b0;
    START = 1'b1;
    sb.push_back(model(16'h0003, 16'h0004, 1'b0, 1'b0));
    @(negedge CLK);
    A = 16'hFFFF; B = 16'hFFFF; C0 = 1'b1; ADD_SUB = 1'b1;
    d0 = n_done;
    wait_done("held");
    chk("held_lit", F, 16'h0007);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    chk("held_single_done", n_done - d0, 1);

    // reset on second RUN clock aborts
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    d0 = n_done;
    chk("abort_f", F, 16'h0000);
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", DONE, 1'b0);
    chk("abort_flags", {C16, CF, ZF}, 3'b000);
    repeat (8) @(negedge CLK);
    chk("abort_no_done", n_done - d0, 0);

    start_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1);
    wait_done("post_abort");

`ifdef OVF_FLAG_EN
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    wait_done("ovf_add");
    chk("ovf_add_lit", {F, OF}, {16'h8000, 1'b1});
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
    wait_done("ovf_sub");
    chk("ovf_sub_lit", {F, OF}, {16'h7FFF, 1'b1});
    start_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1);
    wait_done("ovf_none");
    chk("ovf_none_lit", OF, 1'b0);
`endif

    for (int i = 0; i < 12; i++) begin
      start_op(16'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom), 1);
      wait_done("rand");
    end

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
